// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory bus for multicycle_datapath. Both sides use req/ready:
// a transfer completes on the cycle where req and ready are both high, and the requester holds steady until then.
interface multicycle_datapath_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 24
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [23:0]       imem_rdata;
  logic              imem_ready;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle 24-bit-ISA CPU datapath (fetch/decode/exec/mem/wb); CPU_PERF_CNT_EN adds cycle/retired counters.
// Latency with zero-wait memory: R/ADDI 4, LW 5, SW 4, branch/jump/illegal 3 cycles.
// Backpressure: FETCH and MEM hold every request output steady until the memory raises ready.
module multicycle_datapath #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 24,
  parameter int PC_STEP  = 3,
  parameter int RESET_PC = 10
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  multicycle_datapath_if.master bus,
  output logic [ADDR_W-1:0]    pc,
  output logic                 halted,
  output logic                 illegal,
  output logic [31:0]          cycle_cnt,
  output logic [31:0]          retired_cnt
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_JUMP  = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam int JW = (ADDR_W > 20) ? ADDR_W : 20;

  state_t            state, state_nxt;
  logic [23:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
  logic [DATA_W-1:0] rf [16];

  logic [3:0]        opcode, rs, rt, rd, funct;
  logic [DATA_W-1:0] imm_d, alu_res, rd_rs, rd_rt, wb_dat;
  logic [ADDR_W-1:0] imm_a, step_a, pc_inc, br_tgt, jmp_tgt, pc_nxt;
  logic [JW-1:0]     jt_w;
  logic [3:0]        wb_idx;
  logic              funct_bad, illegal_instr;
  logic              imem_req_c, dmem_req_c, dmem_we_c, pc_ld;

  assign opcode = ir[23:20];
  assign rs     = ir[19:16];
  assign rt     = ir[15:12];
  assign rd     = ir[11:8];
  assign funct  = ir[3:0];

  assign imm_d   = {{(DATA_W-12){ir[11]}}, ir[11:0]};
  assign imm_a   = {{(ADDR_W-12){ir[11]}}, ir[11:0]};
  assign step_a  = ADDR_W'(PC_STEP);
  assign pc_inc  = pc + step_a;
  // Offset arithmetic stays in ADDR_W bits so the target wraps modulo 2^ADDR_W.
  assign br_tgt  = pc_inc + imm_a * step_a;
  assign jt_w    = JW'(ir[19:0]) * JW'(PC_STEP);
  assign jmp_tgt = jt_w[ADDR_W-1:0];

  assign rd_rs  = (rs == 4'd0) ? '0 : rf[rs];
  assign rd_rt  = (rt == 4'd0) ? '0 : rf[rt];
  assign wb_idx = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_dat = (opcode == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    alu_res   = a_q + imm_d;
    funct_bad = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        4'd0:    alu_res = a_q + b_q;
        4'd1:    alu_res = a_q - b_q;
        4'd2:    alu_res = a_q & b_q;
        4'd3:    alu_res = a_q | b_q;
        4'd4:    alu_res = a_q ^ b_q;
        4'd5:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
        4'd6:    alu_res = a_q << b_q[4:0];
        4'd7:    alu_res = a_q >> b_q[4:0];
        default: begin
          alu_res   = '0;
          funct_bad = 1'b1;
        end
      endcase
    end
  end

  assign illegal_instr = (opcode >= 4'd7 && opcode <= 4'd14) || funct_bad;

  always_ff @(posedge Clock) begin
    if (!Reset_n) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    pc_ld      = 1'b0;
    pc_nxt     = pc_inc;
    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (bus.imem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (illegal_instr) begin
          pc_ld     = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          case (opcode)
            OP_RTYPE, OP_ADDI: state_nxt = S_WB;
            OP_LW, OP_SW:      state_nxt = S_MEM;
            OP_BEQ: begin
              pc_ld     = 1'b1;
              pc_nxt    = (a_q == b_q) ? br_tgt : pc_inc;
              state_nxt = S_FETCH;
            end
            OP_BNE: begin
              pc_ld     = 1'b1;
              pc_nxt    = (a_q != b_q) ? br_tgt : pc_inc;
              state_nxt = S_FETCH;
            end
            OP_JUMP: begin
              pc_ld     = 1'b1;
              pc_nxt    = jmp_tgt;
              state_nxt = S_FETCH;
            end
            OP_HALT: state_nxt = S_HALTED;
            default: state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (opcode == OP_SW);
        if (bus.dmem_ready) begin
          if (opcode == OP_SW) begin
            pc_ld     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        pc_ld     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Requests are masked while reset is asserted so an in-flight access is dropped immediately.
  assign bus.imem_req   = imem_req_c && Reset_n;
  assign bus.dmem_req   = dmem_req_c && Reset_n;
  assign bus.dmem_we    = dmem_we_c;
  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = ADDR_W'(alu_q);
  assign bus.dmem_wdata = b_q;
  assign halted         = (state == S_HALTED);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      pc      <= ADDR_W'(RESET_PC);
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (state == S_FETCH && bus.imem_ready) ir <= bus.imem_rdata;
      if (state == S_DECODE) begin
        a_q <= rd_rs;
        b_q <= rd_rt;
      end
      if (state == S_EXEC) begin
        alu_q <= alu_res;
        if (illegal_instr) illegal <= 1'b1;
      end
      if (state == S_MEM && bus.dmem_ready && opcode == OP_LW) mdr_q <= bus.dmem_rdata;
      if (state == S_WB && wb_idx != 4'd0) rf[wb_idx] <= wb_dat;
      if (pc_ld) pc <= pc_nxt;
    end
  end

`ifdef CPU_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;
  logic        retire;

  // Every completion except HALT also loads the PC, so pc_ld marks retirement.
  assign retire = pc_ld || (state == S_EXEC && opcode == OP_HALT);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state != S_HALTED) cyc_q <= cyc_q + 32'd1;
      if (retire)            ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a behavioural instruction/data memory that has programmable wait states.
module tb_multicycle_datapath;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 24;
  localparam logic [23:0] HALT_W = 24'hF00000;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clock = ~Clock;

  multicycle_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] pc;
  logic              halted, illegal;
  logic [31:0]       cycle_cnt, retired_cnt;

  multicycle_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_STEP(3), .RESET_PC(10)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .bus        (bus),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal),
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
  );

  logic [23:0]       imem [0:511];
  logic [DATA_W-1:0] dmem [0:255];
  int   imem_delay = 0;
  int   dmem_delay = 0;
  logic dmem_stall = 1'b0;
  int   iw_cnt = 0;
  int   dw_cnt = 0;
  int   checks = 0;
  int   passed = 0;

  assign bus.imem_ready = bus.imem_req && (iw_cnt >= imem_delay);
  assign bus.imem_rdata = imem[bus.imem_addr[8:0]];
  assign bus.dmem_ready = bus.dmem_req && !dmem_stall && (dw_cnt >= dmem_delay);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];

  always @(posedge Clock) begin
    iw_cnt <= (bus.imem_req && !bus.imem_ready) ? iw_cnt + 1 : 0;
    dw_cnt <= (bus.dmem_req && !bus.dmem_ready) ? dw_cnt + 1 : 0;
    if (bus.dmem_ready && bus.dmem_we) dmem[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
  end

  function automatic logic [23:0] enc_i(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt, input logic [11:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [23:0] enc_r(input logic [3:0] funct, input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    return {4'h0, rs, rt, rd, 4'h0, funct};
  endfunction

  function automatic logic [23:0] enc_j(input logic [19:0] tgt);
    return {4'h6, tgt};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 512; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_imem();
    Reset_n = 1'b0;
    tick();
    checks++; if (bus.imem_req !== 1'b0) $display("FAIL rst_imem_req got %b want 0", bus.imem_req); else passed++;
    checks++; if (bus.dmem_req !== 1'b0) $display("FAIL rst_dmem_req got %b want 0", bus.dmem_req); else passed++;
    checks++; if (pc !== 24'd10) $display("FAIL rst_pc got %0d want 10", pc); else passed++;
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) $display("FAIL rst_flags got %b%b want 00", halted, illegal); else passed++;
`ifdef CPU_PERF_CNT_EN
    checks++; if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) $display("FAIL rst_cnt got %0d/%0d want 0/0", cycle_cnt, retired_cnt); else passed++;
`endif
    Reset_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 24'd10) $display("FAIL first_fetch got req=%b addr=%0d want 1/10", bus.imem_req, bus.imem_addr); else passed++;
  endtask

  task automatic test_alu();
    clear_imem();
    imem[10] = enc_i(4'd1, 4'd0, 4'd1, 12'd5);
    imem[13] = enc_i(4'd1, 4'd0, 4'd2, 12'd7);
    imem[16] = enc_r(4'd0, 4'd3, 4'd1, 4'd2);
    imem[19] = enc_r(4'd1, 4'd6, 4'd1, 4'd2);
    imem[22] = enc_r(4'd5, 4'd7, 4'd1, 4'd2);
    imem[25] = enc_r(4'd6, 4'd8, 4'd1, 4'd2);
    do_reset();
    ticks(11);
    checks++; if (pc !== 24'd16) $display("FAIL alu_wb_pc got %0d want 16", pc); else passed++;
    tick();
    checks++; if (pc !== 24'd19) $display("FAIL alu_pc got %0d want 19", pc); else passed++;
    checks++; if (dut.rf[3] !== 24'd12) $display("FAIL alu_add got %0d want 12", dut.rf[3]); else passed++;
    ticks(12);
    checks++; if (dut.rf[6] !== 24'hFFFFFE) $display("FAIL alu_sub got %h want fffffe", dut.rf[6]); else passed++;
    checks++; if (dut.rf[7] !== 24'd1) $display("FAIL alu_slt got %0d want 1", dut.rf[7]); else passed++;
    checks++; if (dut.rf[8] !== 24'd640) $display("FAIL alu_sll got %0d want 640", dut.rf[8]); else passed++;
  endtask

  task automatic test_mem_wait();
    clear_imem();
    imem[10] = enc_i(4'd1, 4'd0, 4'd1, 12'd5);
    imem[13] = enc_i(4'd1, 4'd0, 4'd2, 12'd7);
    imem[16] = enc_r(4'd0, 4'd3, 4'd1, 4'd2);
    imem[19] = enc_i(4'd1, 4'd0, 4'd5, 12'd40);
    imem[22] = enc_i(4'd3, 4'd5, 4'd3, 12'd0);
    imem[25] = enc_i(4'd2, 4'd5, 4'd4, 12'd0);
    dmem_delay = 3;
    do_reset();
    ticks(16);
    checks++; if (pc !== 24'd22) $display("FAIL mem_pre_pc got %0d want 22", pc); else passed++;
    ticks(3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 24'd40 || bus.dmem_wdata !== 24'd12)
        $display("FAIL sw_hold%0d got req=%b we=%b addr=%0d wdata=%0d want 1/1/40/12", k, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wdata);
      else passed++;
      tick();
    end
    checks++; if (pc !== 24'd25) $display("FAIL sw_pc got %0d want 25", pc); else passed++;
    checks++; if (dmem[40] !== 24'd12) $display("FAIL sw_data got %0d want 12", dmem[40]); else passed++;
    ticks(3);
    checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 24'd40) $display("FAIL lw_req got req=%b we=%b addr=%0d want 1/0/40", bus.dmem_req, bus.dmem_we, bus.dmem_addr); else passed++;
    ticks(4);
    checks++; if (pc !== 24'd25) $display("FAIL lw_wb_pc got %0d want 25", pc); else passed++;
    tick();
    checks++; if (pc !== 24'd28 || dut.rf[4] !== 24'd12) $display("FAIL lw_done got pc=%0d r4=%0d want 28/12", pc, dut.rf[4]); else passed++;
    dmem_delay = 0;
  endtask

  task automatic test_branch();
    clear_imem();
    imem[10] = enc_i(4'd1, 4'd0, 4'd1, 12'd5);
    imem[13] = enc_i(4'd1, 4'd0, 4'd2, 12'd1);
    imem[16] = enc_i(4'd1, 4'd2, 4'd2, 12'd1);
    imem[19] = enc_i(4'd1, 4'd2, 4'd2, 12'd1);
    imem[22] = enc_i(4'd4, 4'd1, 4'd1, 12'hFFE);
    imem[25] = enc_i(4'd5, 4'd1, 4'd2, 12'd2);
    do_reset();
    ticks(18);
    checks++; if (pc !== 24'd22) $display("FAIL beq_pre_pc got %0d want 22", pc); else passed++;
    tick();
    checks++; if (pc !== 24'd19) $display("FAIL beq_taken got %0d want 19", pc); else passed++;
    imem[22] = enc_i(4'd5, 4'd1, 4'd1, 12'hFFE);
    ticks(4);
    checks++; if (dut.rf[2] !== 24'd4) $display("FAIL beq_loop_r2 got %0d want 4", dut.rf[2]); else passed++;
    ticks(3);
    checks++; if (pc !== 24'd25) $display("FAIL bne_not_taken got %0d want 25", pc); else passed++;
    ticks(3);
    checks++; if (pc !== 24'd34) $display("FAIL bne_taken got %0d want 34", pc); else passed++;
  endtask

  task automatic test_jump_halt();
    clear_imem();
    imem[10] = enc_j(20'd100);
    imem_delay = 2;
    do_reset();
    ticks(4);
    checks++; if (pc !== 24'd10) $display("FAIL jump_wait_pc got %0d want 10", pc); else passed++;
    tick();
    checks++; if (pc !== 24'd300) $display("FAIL jump_pc got %0d want 300", pc); else passed++;
    ticks(4);
    checks++; if (halted !== 1'b0) $display("FAIL halt_early got %b want 0", halted); else passed++;
    tick();
    checks++; if (halted !== 1'b1 || pc !== 24'd300) $display("FAIL halt got halted=%b pc=%0d want 1/300", halted, pc); else passed++;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || pc !== 24'd300 || halted !== 1'b1)
        $display("FAIL halted_idle%0d got ireq=%b dreq=%b pc=%0d halted=%b want 0/0/300/1", k, bus.imem_req, bus.dmem_req, pc, halted);
      else passed++;
    end
`ifdef CPU_PERF_CNT_EN
    checks++; if (cycle_cnt !== 32'd10 || retired_cnt !== 32'd2) $display("FAIL halt_cnt got %0d/%0d want 10/2", cycle_cnt, retired_cnt); else passed++;
`endif
    imem_delay = 0;
  endtask

  task automatic test_illegal();
    clear_imem();
    imem[10] = enc_i(4'd1, 4'd0, 4'd1, 12'd5);
    imem[13] = 24'h912345;
    imem[16] = enc_i(4'd1, 4'd0, 4'd0, 12'd9);
    imem[19] = 24'h011309;
    do_reset();
    ticks(4);
    checks++; if (illegal !== 1'b0 || pc !== 24'd13) $display("FAIL ill_pre got ill=%b pc=%0d want 0/13", illegal, pc); else passed++;
    ticks(3);
    checks++; if (illegal !== 1'b1 || pc !== 24'd16) $display("FAIL ill_op got ill=%b pc=%0d want 1/16", illegal, pc); else passed++;
    checks++; if (dut.rf[1] !== 24'd5 || dut.rf[2] !== 24'd0 || dut.rf[3] !== 24'd0) $display("FAIL ill_regs got %0d/%0d/%0d want 5/0/0", dut.rf[1], dut.rf[2], dut.rf[3]); else passed++;
    ticks(4);
    checks++; if (pc !== 24'd19 || dut.rf[0] !== 24'd0) $display("FAIL r0_write got pc=%0d r0=%0d want 19/0", pc, dut.rf[0]); else passed++;
    ticks(3);
    checks++; if (pc !== 24'd22 || dut.rf[3] !== 24'd0 || illegal !== 1'b1) $display("FAIL ill_funct got pc=%0d r3=%0d ill=%b want 22/0/1", pc, dut.rf[3], illegal); else passed++;
`ifdef CPU_PERF_CNT_EN
    checks++; if (cycle_cnt !== 32'd14 || retired_cnt !== 32'd4) $display("FAIL ill_cnt got %0d/%0d want 14/4", cycle_cnt, retired_cnt); else passed++;
`endif
  endtask

  task automatic test_reset_mid_mem();
    clear_imem();
    imem[10] = enc_i(4'd3, 4'd0, 4'd0, 12'd40);
    dmem_stall = 1'b1;
    do_reset();
    ticks(5);
    checks++; if (bus.dmem_req !== 1'b1) $display("FAIL stall_req got %b want 1", bus.dmem_req); else passed++;
    Reset_n = 1'b0;
    #1;
    checks++; if (bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b0) $display("FAIL rst_mask got d=%b i=%b want 0/0", bus.dmem_req, bus.imem_req); else passed++;
    tick();
    Reset_n = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.dmem_req !== 1'b0 || pc !== 24'd10) $display("FAIL mid_rst got ireq=%b dreq=%b pc=%0d want 1/0/10", bus.imem_req, bus.dmem_req, pc); else passed++;
`ifdef CPU_PERF_CNT_EN
    checks++; if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) $display("FAIL mid_rst_cnt got %0d/%0d want 0/0", cycle_cnt, retired_cnt); else passed++;
`endif
    dmem_stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_jump_halt();
    test_illegal();
    test_reset_mid_mem();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
